// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e       : controller states (idle / running / result held)
//   DefaultWidth  : default operand and result width in bits
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full adder.
//   I0, I1 : addend bits
//   CIN    : carry in
//   O      : sum bit
//   COUT   : carry out
module full_adder (
  input  logic I0,
  input  logic I1,
  input  logic CIN,
  output logic O,
  output logic COUT
);

  logic p;

  assign p    = I0 ^ I1;
  assign O    = p ^ CIN;
  assign COUT = (I0 & I1) | (CIN & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit per clock, LSB first, through a single full adder.
//   CLKIN     : clock, rising edge
//   RESETN    : asynchronous active-low reset
//   I0, I1    : operands, sampled on accept
//   CIN       : carry in, sampled on accept
//   IN_VALID  : operands valid
//   IN_READY  : block idle and able to accept
//   O, COUT   : sum and carry out (valid while OUT_VALID)
//   OUT_VALID : result valid
//   OUT_READY : consumer takes the result
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             CLKIN,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_full_adder (
    .I0   (a_q[0]),
    .I1   (b_q[0]),
    .CIN  (carry_q),
    .O    (fa_sum),
    .COUT (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (IN_VALID) begin
          a_d     = I0;
          b_d     = I1;
          carry_d = CIN;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // Sum bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts.
        res_d   = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (OUT_READY) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IN_READY  = (state_q == StIdle);
  assign OUT_VALID = (state_q == StDone);
  assign O         = res_q;
  assign COUT      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic [7:0] a8, b8, o8;
  logic       ci8, iv8, ir8, co8, ov8, or8;

  logic [0:0] a1, b1, o1;
  logic       ci1, iv1, ir1, co1, ov1, or1;

  int n_chk;
  int n_bad;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .CLKIN     (clk),
    .RESETN    (rst_n),
    .I0        (a8),
    .I1        (b8),
    .CIN       (ci8),
    .IN_VALID  (iv8),
    .IN_READY  (ir8),
    .O         (o8),
    .COUT      (co8),
    .OUT_VALID (ov8),
    .OUT_READY (or8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .CLKIN     (clk),
    .RESETN    (rst_n),
    .I0        (a1),
    .I1        (b1),
    .CIN       (ci1),
    .IN_VALID  (iv1),
    .IN_READY  (ir1),
    .O         (o1),
    .COUT      (co1),
    .OUT_VALID (ov1),
    .OUT_READY (or1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with the WIDTH=8 block idle.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input int hold, input bit disturb,
                      input logic [7:0] eo, input logic eco);
    int cyc;
    check({tag, " in_ready"}, 32'(ir8), 32'd1);
    a8 = a; b8 = b; ci8 = ci; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    if (disturb) begin
      a8 = ~a; b8 = 8'h77; ci8 = ~ci; iv8 = 1'b1;
    end
    cyc = 0;
    while (!ov8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3 && disturb) begin
        a8 = 8'hC3; b8 = 8'h5F;
      end
    end
    iv8 = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'd8);
    check({tag, " O"}, 32'(o8), 32'(eo));
    check({tag, " COUT"}, 32'(co8), 32'(eco));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 32'(ov8), 32'd1);
      check({tag, " hold O"}, 32'(o8), 32'(eo));
      check({tag, " hold COUT"}, 32'(co8), 32'(eco));
    end
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    check({tag, " post out_valid"}, 32'(ov8), 32'd0);
    check({tag, " post in_ready"}, 32'(ir8), 32'd1);
  endtask

  task automatic run1(input string tag, input logic a, input logic b, input logic ci,
                      input logic eo, input logic eco);
    int cyc;
    check({tag, " in_ready"}, 32'(ir1), 32'd1);
    a1 = a; b1 = b; ci1 = ci; iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    cyc = 0;
    while (!ov1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd1);
    check({tag, " O"}, 32'(o1), 32'(eo));
    check({tag, " COUT"}, 32'(co1), 32'(eco));
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    check({tag, " post out_valid"}, 32'(ov1), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
    a1 = '0; b1 = '0; ci1 = 1'b0; iv1 = 1'b0; or1 = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst in_ready", 32'(ir8), 32'd1);
    check("rst out_valid", 32'(ov8), 32'd0);
    check("rst O", 32'(o8), 32'd0);
    check("rst COUT", 32'(co8), 32'd0);
    check("rst1 in_ready", 32'(ir1), 32'd1);
    check("rst1 out_valid", 32'(ov1), 32'd0);

    // Release and accept on the very next rising edge.
    rst_n = 1'b1;
    run8("ff+01", 8'hFF, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b1);
    run8("5a+3c+1", 8'h5A, 8'h3C, 1'b1, 5, 1'b0, 8'h97, 1'b0);

    // Abort mid-run.
    a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort in_ready", 32'(ir8), 32'd1);
    check("abort out_valid", 32'(ov8), 32'd0);
    check("abort O", 32'(o8), 32'd0);
    check("abort COUT", 32'(co8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8("10+20", 8'h10, 8'h20, 1'b0, 0, 1'b0, 8'h30, 1'b0);

    run8("disturb", 8'h12, 8'h34, 1'b0, 0, 1'b1, 8'h46, 1'b0);
    run8("80+80+1", 8'h80, 8'h80, 1'b1, 1, 1'b0, 8'h01, 1'b1);
    run8("00+00", 8'h00, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0);

    run1("w1 1+1+1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    run1("w1 0+0+1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run1("w1 1+0+0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run1("w1 1+1+0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
